// File: rtl/run_length_meter.sv
// Measures the length of runs of consecutive 1 samples on a serial level,
// reporting each completed run and keeping running max/count statistics.
`default_nettype none

module run_length_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             clr_stats,
    output logic [WIDTH-1:0] len,
    output logic             len_vld,
    output logic             ovf,
    output logic [WIDTH-1:0] max_len,
    output logic [WIDTH-1:0] run_cnt
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SAT  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] len_q;
    logic             len_vld_q;
    logic             ovf_q;
    logic [WIDTH-1:0] max_len_q;
    logic [WIDTH-1:0] run_cnt_q;

    logic             done_d;
    logic [WIDTH-1:0] new_len_d;
    logic [WIDTH-1:0] max_len_d;
    logic [WIDTH-1:0] run_cnt_d;

    // A run completes on the edge that samples a 0 while counting or saturated.
    always_comb begin
        done_d    = ((state_q == S_RUN) || (state_q == S_SAT)) && !in;
        new_len_d = (state_q == S_SAT) ? ALL_ONES : cnt_q;
        max_len_d = max_len_q;
        run_cnt_d = run_cnt_q;
        if (clr_stats) begin
            max_len_d = '0;
            run_cnt_d = '0;
        end else if (done_d) begin
            if (new_len_d > max_len_q) begin
                max_len_d = new_len_d;
            end
            if (run_cnt_q != ALL_ONES) begin
                run_cnt_d = run_cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            len_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            len_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in && en) begin
                        state_q <= S_RUN;
                        cnt_q   <= ONE;
                    end
                end
                S_RUN: begin
                    if (in) begin
                        if (cnt_q == ALL_ONES) begin
                            state_q <= S_SAT;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end else begin
                        state_q   <= S_IDLE;
                        len_q     <= cnt_q;
                        len_vld_q <= 1'b1;
                    end
                end
                S_SAT: begin
                    if (!in) begin
                        state_q   <= S_IDLE;
                        len_q     <= ALL_ONES;
                        len_vld_q <= 1'b1;
                        ovf_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_len_q <= '0;
            run_cnt_q <= '0;
        end else begin
            max_len_q <= max_len_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign len     = len_q;
    assign len_vld = len_vld_q;
    assign ovf     = ovf_q;
    assign max_len = max_len_q;
    assign run_cnt = run_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_run_length_meter.sv
// Randomized and directed checks of run_length_meter against an integer run model.
`default_nettype none

module tb_run_length_meter;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst;
    logic             in;
    logic             en;
    logic             clr_stats;
    logic [WIDTH-1:0] len;
    logic             len_vld;
    logic             ovf;
    logic [WIDTH-1:0] max_len;
    logic [WIDTH-1:0] run_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference state: whether a run is open and its unbounded length so far.
    bit m_in_run;
    int m_run_len;
    int m_len, m_vld, m_ovf, m_max, m_cnt;

    run_length_meter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .en        (en),
        .clr_stats (clr_stats),
        .len       (len),
        .len_vld   (len_vld),
        .ovf       (ovf),
        .max_len   (max_len),
        .run_cnt   (run_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_in_run  = 1'b0;
        m_run_len = 0;
        m_len = 0; m_vld = 0; m_ovf = 0; m_max = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int done_len;
        bit done;
        if (!rst) begin
            model_reset();
            return;
        end
        done  = 1'b0;
        m_vld = 0;
        m_ovf = 0;
        if (m_in_run) begin
            if (in) begin
                m_run_len++;
            end else begin
                m_in_run = 1'b0;
                done     = 1'b1;
                done_len = (m_run_len > MAXV) ? MAXV : m_run_len;
                m_len    = done_len;
                m_vld    = 1;
                m_ovf    = (m_run_len > MAXV) ? 1 : 0;
            end
        end else if (in && en) begin
            m_in_run  = 1'b1;
            m_run_len = 1;
        end
        if (clr_stats) begin
            m_max = 0;
            m_cnt = 0;
        end else if (done) begin
            if (done_len > m_max) m_max = done_len;
            if (m_cnt < MAXV) m_cnt++;
        end
    endtask

    task automatic check_outputs();
        chk("len",     int'(len),     m_len);
        chk("len_vld", int'(len_vld), m_vld);
        chk("ovf",     int'(ovf),     m_ovf);
        chk("max_len", int'(max_len), m_max);
        chk("run_cnt", int'(run_cnt), m_cnt);
    endtask

    task automatic cycle(input bit i, input bit e, input bit c);
        in        = i;
        en        = e;
        clr_stats = c;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int ones, input int zeros, input bit c_at_end);
        for (int k = 0; k < ones; k++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, c_at_end);
        for (int k = 1; k < zeros; k++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; in = 1'b0; en = 1'b0; clr_stats = 1'b0;
        model_reset();
        #1;
        chk("reset_len",     int'(len),     0);
        chk("reset_vld",     int'(len_vld), 0);
        chk("reset_max",     int'(max_len), 0);
        chk("reset_run_cnt", int'(run_cnt), 0);
        #11 rst = 1'b1;

        // Basic, exact-max and saturated runs
        cycle(1'b0, 1'b1, 1'b0);
        run(5, 2, 1'b0);
        run(MAXV, 2, 1'b0);
        run(20, 2, 1'b0);
        run(MAXV + 1, 1, 1'b0);
        // 1-0-1 pattern and back-to-back runs
        run(1, 1, 1'b0);
        run(1, 1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        run(3, 1, 1'b0);
        run(7, 1, 1'b0);
        run(2, 2, 1'b0);

        // en gating only the start; en dropped mid-run is ignored
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Clear coincident with run completion
        run(4, 2, 1'b1);

        // Reset in the middle of a run, with the level held high across release
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        run(2, 2, 1'b0);

        // Many runs without clears to saturate run_cnt
        for (int r = 0; r < 20; r++) run(int'($urandom_range(1, 6)), 1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cycle(bit'($urandom_range(0, 3) != 0),
                  bit'($urandom_range(0, 3) != 0),
                  bit'($urandom_range(0, 15) == 0));
        end
        for (int r = 0; r < 60; r++) begin
            run(int'($urandom_range(0, 20)), int'($urandom_range(1, 3)),
                bit'($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
